arcade_input_ctrl: RTL and testbench

- Input conditioning stage directly upstream of the pacman-family core's in0_reg/in1_reg ports.
- Decodes PS/2 key events and merges both joysticks.
- Applies orientation remap for horizontal (rotated) display.
- Shapes coin presses into fixed-width, non-repeating pulses so a held key or button inserts exactly one coin.
- Drives the core's active-low input registers directly.

---
 rtl/arcade_input_ctrl_if.sv | 21 ++
 rtl/arcade_input_ctrl.sv | 130 +++++++++++++
 tb/tb_arcade_input_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_ctrl_if.sv
// Control-side bus of the arcade input stage: PS/2 events, both joysticks,
// orientation select, and the core's active-low input registers.
interface arcade_input_ctrl_if;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [7:0]  in0_reg;
  logic [7:0]  in1_reg;
  logic        key_event;

  modport master (
    output ps2_key, joystick_0, joystick_1, rotate,
    input  in0_reg, in1_reg, key_event
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, rotate,
    output in0_reg, in1_reg, key_event
  );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Input conditioning for the pacman-family core: PS/2 key latches merged with
// both joysticks, optional orientation remap, and one-shot coin pulse shaping.
module arcade_input_ctrl #(
  parameter int unsigned COIN_TICKS = 400000,
  parameter int unsigned GAP_TICKS  = 400000
) (
  input logic           clk_sys,
  input logic           reset_n,
  arcade_input_ctrl_if.slave bus
);

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic start1;
    logic start2;
    logic coin;
  } keys_t;

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP, C_RELEASE} coin_st_t;

  localparam logic [19:0] COIN_LD = 20'(COIN_TICKS - 1);
  localparam logic [19:0] GAP_LD  = 20'(GAP_TICKS - 1);

  keys_t      key_q;
  logic       tog_q, primed, ps2_ev, key_event_q;
  logic [7:0] in0_q, in1_q;
  coin_st_t   coin_st;
  logic [19:0] cnt;
  logic       coin_out;

  // primed masks the first cycle so a toggle bit already high at reset
  // release is not mistaken for an event
  assign ps2_ev = primed & (bus.ps2_key[10] ^ tog_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q       <= 1'b0;
      primed      <= 1'b0;
      key_event_q <= 1'b0;
      key_q       <= '0;
    end else begin
      tog_q       <= bus.ps2_key[10];
      primed      <= 1'b1;
      key_event_q <= ps2_ev;
      if (ps2_ev) begin
        // arrows match with or without the E0 prefix; others need it clear
        case (bus.ps2_key[7:0])
          8'h75: key_q.up    <= bus.ps2_key[9];
          8'h72: key_q.down  <= bus.ps2_key[9];
          8'h6B: key_q.left  <= bus.ps2_key[9];
          8'h74: key_q.right <= bus.ps2_key[9];
          8'h14, 8'h05: if (!bus.ps2_key[8]) key_q.start1 <= bus.ps2_key[9];
          8'h29, 8'h06: if (!bus.ps2_key[8]) key_q.start2 <= bus.ps2_key[9];
          8'h04: if (!bus.ps2_key[8]) key_q.coin <= bus.ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  logic [15:0] j;
  logic r_u, r_d, r_l, r_r, s1, s2, raw_coin;
  logic up, down, left, right;
  logic unused_joy;

  assign j          = bus.joystick_0 | bus.joystick_1;
  assign unused_joy = &{1'b0, j[15:7]};
  assign r_u        = key_q.up     | j[3];
  assign r_d        = key_q.down   | j[2];
  assign r_l        = key_q.left   | j[1];
  assign r_r        = key_q.right  | j[0];
  assign s1         = key_q.start1 | j[4];
  assign s2         = key_q.start2 | j[5];
  assign raw_coin   = key_q.coin   | j[6];

  // horizontal cabinet: stick is turned a quarter, so each direction shifts
  assign up    = bus.rotate ? r_l : r_u;
  assign down  = bus.rotate ? r_r : r_d;
  assign left  = bus.rotate ? r_d : r_l;
  assign right = bus.rotate ? r_u : r_r;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_st  <= C_IDLE;
      cnt      <= '0;
      coin_out <= 1'b0;
    end else begin
      case (coin_st)
        C_IDLE: if (raw_coin) begin
          coin_st  <= C_PULSE;
          cnt      <= COIN_LD;
          coin_out <= 1'b1;
        end
        C_PULSE: if (cnt == '0) begin
          coin_st  <= C_GAP;
          cnt      <= GAP_LD;
          coin_out <= 1'b0;
        end else begin
          cnt <= cnt - 20'd1;
        end
        C_GAP: if (cnt == '0) coin_st <= C_RELEASE;
               else           cnt     <= cnt - 20'd1;
        // a held coin parks here until let go, so it counts once
        C_RELEASE: if (!raw_coin) coin_st <= C_IDLE;
        default: begin
          coin_st  <= C_IDLE;
          coin_out <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      in0_q <= 8'hFF;
      in1_q <= 8'hFF;
    end else begin
      in0_q <= ~{2'b00, coin_out, 1'b0, down, right, left, up};
      in1_q <= ~{1'b0, s2, s1, 5'b00000};
    end
  end

  assign bus.in0_reg   = in0_q;
  assign bus.in1_reg   = in1_q;
  assign bus.key_event = key_event_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed scenarios plus random stimulus, all
// compared each cycle against a cycle-indexed behavioural model.
module tb_arcade_input_ctrl;
  localparam int CT = 4;
  localparam int GT = 3;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  arcade_input_ctrl_if bus();

  arcade_input_ctrl #(.COIN_TICKS(CT), .GAP_TICKS(GT)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // key functions: 0 up, 1 down, 2 left, 3 right, 4 start1, 5 start2, 6 coin
  bit [6:0]   mk;
  bit         m_tog, m_coin, m_armed;
  int         m_since;
  longint     m_cyc, m_trig;
  logic [7:0] e_in0 = 8'hFF, e_in1 = 8'hFF;
  logic       e_kev = 1'b0;

  function automatic int key_fn(input logic [8:0] code);
    case (code[7:0])
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: ;
    endcase
    if (code == 9'h014 || code == 9'h005) return 4;
    if (code == 9'h029 || code == 9'h006) return 5;
    if (code == 9'h004) return 6;
    return -1;
  endfunction

  task automatic model_reset();
    mk = '0; m_coin = 0; m_armed = 1; m_since = 0; m_cyc = 0; m_trig = -100;
    e_in0 = 8'hFF; e_in1 = 8'hFF; e_kev = 1'b0;
  endtask

  task automatic model_edge();
    logic [15:0] jj;
    logic [3:0]  phys, outd;  // {R, L, D, U}
    logic        raw_c, ev;
    int          k;
    m_cyc++;
    jj    = bus.joystick_0 | bus.joystick_1;
    phys  = {mk[3] | jj[0], mk[2] | jj[1], mk[1] | jj[2], mk[0] | jj[3]};
    // rotated: up<-L, down<-R, left<-D, right<-U
    outd  = bus.rotate ? {phys[0], phys[1], phys[3], phys[2]}
                       : {phys[3], phys[2], phys[1], phys[0]};
    // outd = {right, left, down, up}
    e_in0 = ~{2'b00, m_coin, 1'b0, outd[1], outd[3], outd[2], outd[0]};
    e_in1 = ~{1'b0, mk[5] | jj[5], mk[4] | jj[4], 5'b00000};
    raw_c = mk[6] | jj[6];
    if (m_armed && raw_c) begin
      m_trig = m_cyc; m_armed = 0;
    end else if (!m_armed && m_cyc > m_trig + CT + GT && !raw_c) begin
      m_armed = 1;
    end
    m_coin = (m_cyc >= m_trig) && (m_cyc < m_trig + CT);
    ev = (m_since > 0) && (bus.ps2_key[10] != m_tog);
    m_tog = bus.ps2_key[10];
    m_since++;
    e_kev = ev;
    if (ev) begin
      k = key_fn(bus.ps2_key[8:0]);
      if (k >= 0) mk[k] = bus.ps2_key[9];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_sys or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_edge();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      chk("in0", {8'h00, bus.in0_reg}, {8'h00, e_in0});
      chk("in1", {8'h00, bus.in1_reg}, {8'h00, e_in1});
      chk("kev", {15'h0, bus.key_event}, {15'h0, e_kev});
    end
  endtask

  task automatic send(input logic pressed, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, code};
  endtask

  int cnt;
  logic [8:0] codes [12] = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h175, 9'h014,
                             9'h005, 9'h029, 9'h006, 9'h004, 9'h114, 9'h1F0};

  initial begin
    bus.ps2_key = 11'h400;
    bus.joystick_0 = '0;
    bus.joystick_1 = '0;
    bus.rotate = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_in0", {8'h00, bus.in0_reg}, 16'h00FF);
    chk("rst_in1", {8'h00, bus.in1_reg}, 16'h00FF);
    reset_n = 1'b1;

    cnt = 0;
    for (int i = 0; i < 10; i++) begin cyc(1); cnt += int'(bus.key_event); end
    chk("rst_nokev", 16'(cnt), 16'd0);
    chk("rst_in0_post", {8'h00, bus.in0_reg}, 16'h00FF);

    // PS/2 up make then break
    send(1'b1, 9'h075);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1); cnt += int'(bus.key_event);
      if (i == 1) chk("up_make", {8'h00, bus.in0_reg}, 16'h00FE);
    end
    chk("up_kev_once", 16'(cnt), 16'd1);
    send(1'b0, 9'h075);
    cyc(2);
    chk("up_break", {8'h00, bus.in0_reg}, 16'h00FF);

    // rotate with joystick left
    bus.rotate = 1'b1; bus.joystick_0 = 16'h0002;
    cyc(1);
    chk("rot_left_up", {8'h00, bus.in0_reg}, 16'h00FE);
    bus.rotate = 1'b0;
    cyc(1);
    chk("norot_left", {8'h00, bus.in0_reg}, 16'h00FD);
    bus.joystick_0 = '0;
    cyc(2);

    // held coin gives exactly one pulse
    bus.joystick_1 = 16'h0040;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin cyc(1); cnt += int'(!bus.in0_reg[5]); end
    chk("coin_held_w", 16'(cnt), 16'(CT));
    chk("coin_held_end", {15'h0, bus.in0_reg[5]}, 16'd1);
    bus.joystick_1 = '0;
    cyc(2);
    bus.joystick_1 = 16'h0040;
    cyc(1);
    cnt = int'(!bus.in0_reg[5]);
    bus.joystick_1 = '0;
    for (int i = 0; i < 19; i++) begin cyc(1); cnt += int'(!bus.in0_reg[5]); end
    chk("coin_short_w", 16'(cnt), 16'(CT));

    // start merge: F1 key plus joystick start2
    send(1'b1, 9'h005); bus.joystick_0 = 16'h0020;
    cyc(2);
    chk("start_merge", {8'h00, bus.in1_reg}, 16'h009F);
    send(1'b0, 9'h005);
    cyc(2);
    chk("start_f1_brk", {8'h00, bus.in1_reg}, 16'h00BF);
    bus.joystick_0 = '0;
    cyc(3);

    // reset in the middle of a coin pulse
    bus.joystick_0 = 16'h0040;
    cyc(2);
    chk("pulse_on", {8'h00, bus.in0_reg}, 16'h00DF);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid", {8'h00, bus.in0_reg}, 16'h00FF);
    @(negedge clk_sys);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin cyc(1); cnt += int'(!bus.in0_reg[5]); end
    chk("coin_after_rst", 16'(cnt), 16'(CT));
    bus.joystick_0 = '0;
    cyc(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 2)
        bus.joystick_0 = 16'($urandom & $urandom & 32'h7F) | 16'($urandom & 32'hFF80);
      if ($urandom_range(0, 9) < 2)
        bus.joystick_1 = 16'($urandom & $urandom & $urandom & 32'h7F);
      if ($urandom_range(0, 19) == 0) bus.rotate = ~bus.rotate;
      if ($urandom_range(0, 6) == 0) begin
        if ($urandom_range(0, 3) == 0) send(1'($urandom), 9'($urandom));
        else send(1'($urandom), codes[$urandom_range(0, 11)]);
      end else if ($urandom_range(0, 9) == 0) begin
        bus.ps2_key[9:0] = 10'($urandom);  // non-toggling noise
      end
      if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
      else if (!reset_n && $urandom_range(0, 2) == 0) reset_n = 1'b1;
      cyc(1);
    end
    reset_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
